// File: rtl/mem_resp_pkg.sv
// Shared types and default widths for the memory responder and the datapath that talks to it.
package mem_resp_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;
    localparam int CNT_W      = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP,
        ST_HOLD
    } state_e;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_e;

endpackage

// File: rtl/sp_ram.sv
// Synchronous single-port RAM with a registered read port; contents are never reset.
module sp_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rdata_q;

    // A write landing on the same edge as reset is dropped so an interrupted access leaves no trace.
    always_ff @(posedge clk) begin
        if (en && we && !reset) begin
            mem_q[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (en && !we) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: latches a level-held read/write request, waits WAIT_CYCLES,
// performs the RAM access and answers with a one-cycle ready pulse (return-to-zero handshake).
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic             HAS_WAIT = (WAIT_CYCLES > 0);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_READ;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_rd && mem_wr) begin
                    err_d   = 1'b1;
                    state_d = ST_HOLD;
                end else if (mem_rd || mem_wr) begin
                    op_d    = mem_wr ? OP_WRITE : OP_READ;
                    addr_d  = addr;
                    if (mem_wr) begin
                        wdata_d = wdata;
                    end
                    cnt_d   = CNT_LOAD;
                    state_d = HAS_WAIT ? ST_WAIT : ST_ACCESS;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                // A request still held here was already served; park until it drops.
                state_d = (mem_rd || mem_wr) ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if (!mem_rd && !mem_wr) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    logic ram_en;
    logic ram_we;

    assign ram_en = (state_q == ST_ACCESS);
    assign ram_we = (op_q == OP_WRITE);

    sp_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (rdata)
    );

    assign ready = (state_q == ST_RESP);
    assign busy  = (state_q != ST_IDLE) && (state_q != ST_HOLD);
    assign err   = err_q;

endmodule
